// File: rtl/lsu_master.sv
// Load/store unit bus master: takes one pipeline access at a time, runs a single
// memory transaction, aligns/extends load data and returns a response.
module lsu_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        live_q;
  logic        we_q;
  logic [2:0]  type_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        capture;
  logic        req_bad;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        in_req;

  // Rejected without touching memory: illegal encodings or misaligned h/w accesses.
  always_comb begin
    req_bad = (req_type == 3'b011) || (req_type == 3'b110) || (req_type == 3'b111) ||
              ((req_type[1:0] == 2'b01) && req_addr[0]) ||
              ((req_type[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    ld_byte = mem_rdata[8*addr_q[1:0] +: 8];
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (type_q[1:0])
      2'b00:   ld_data = {{24{~type_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~type_q[2] & ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid && live_q) begin
          capture = 1'b1;
          rdata_d = '0;
          err_d   = req_bad;
          state_d = req_bad ? StResp : StReq;
        end
      end
      StReq: begin
        if (mem_gnt) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rvalid) begin
          err_d   = mem_err;
          rdata_d = (mem_err || we_q) ? '0 : ld_data;
          state_d = StResp;
        end else if (cnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      live_q  <= 1'b0;
      we_q    <= 1'b0;
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (capture) begin
        we_q    <= req_we;
        type_q  <= req_type;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // live_q keeps req_ready low until the first edge after reset is released.
  assign req_ready = (state_q == StIdle) && live_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign in_req    = (state_q == StReq);
  assign mem_req   = in_req;
  assign mem_we    = in_req & we_q;
  assign mem_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;

  always_comb begin
    mem_be    = '0;
    mem_wdata = '0;
    if (in_req) begin
      case (type_q[1:0])
        2'b00: begin
          mem_be    = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          mem_be    = 4'b0011 << addr_q[1:0];
          mem_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = wdata_q;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_master.md
LSU_MASTER -- requirements
Module: lsu_master

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles allowed before mem_rvalid arrives (legal range 1..255).
REQ-002 clk  in  1  single clock; all logic updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  pipeline access request.
REQ-005 req_ready  out  1  request accepted when high together with req_valid.
REQ-006 req_we  in  1  1=store, 0=load.
REQ-007 req_type  in  3  access type: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 rsp_valid  out  1  response valid.
REQ-011 rsp_ready  in  1  response consumed.
REQ-012 rsp_rdata  out  32  extended load data.
REQ-013 rsp_err  out  1  misaligned access, illegal type, bus error or timeout.
REQ-014 mem_req  out  1  memory request.
REQ-015 mem_gnt  in  1  memory accepted the request.
REQ-016 mem_we  out  1  memory write.
REQ-017 mem_addr  out  32  word address, bits [1:0] = 00.
REQ-018 mem_be  out  4  byte enables.
REQ-019 mem_wdata  out  32  lane-replicated store data.
REQ-020 mem_rvalid  in  1  read data or write acknowledge.
REQ-021 mem_rdata  in  32  read word.
REQ-022 mem_err  in  1  bus error, qualified by mem_rvalid.

Function
REQ-023 The FSM SHALL have four states: IDLE, REQ, WAIT and RESP.
REQ-024 req_ready SHALL be 1 only in IDLE; on acceptance, addr, type, we and wdata SHALL be registered.
REQ-025 The following SHALL go from IDLE directly to RESP with rsp_err=1 and rsp_rdata=0, with no memory access: illegal type (011, 110, 111), h/hu with addr[0]=1, or w with addr[1:0]!=00.
REQ-026 Legal accepted requests SHALL go from IDLE to REQ.
REQ-027 In REQ, mem_req SHALL be 1 and mem_we, mem_addr, mem_be and mem_wdata SHALL stay stable until mem_gnt is sampled high; the FSM then moves to WAIT and mem_req is 0 the next cycle.
REQ-028 mem_be SHALL be 0001<<addr[1:0] for byte access, 0011<<addr[1:0] for half access, and 1111 for word access.
REQ-029 mem_wdata SHALL be {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, and wdata for word.
REQ-030 In WAIT, an 8-bit counter cleared at grant SHALL increment every cycle; mem_rvalid=1 moves to RESP, latching rsp_err=mem_err.
REQ-031 If mem_rvalid has not arrived when the counter reaches TIMEOUT, the FSM SHALL move to RESP with rsp_err=1 and rsp_rdata=0.
REQ-032 mem_rvalid SHALL be ignored in IDLE, REQ and RESP, including late responses after a timeout.
REQ-033 For a successful load, the byte lane SHALL be selected by addr[1:0] and the half lane by addr[1]; the value is zero-extended when type[2]=1, otherwise sign-extended.
REQ-034 rsp_rdata SHALL be 0 for stores and for errors.
REQ-035 In RESP, rsp_valid=1 SHALL hold with stable data until rsp_ready; the FSM then returns to IDLE, so the next acceptance is no earlier than the following cycle.
REQ-036 Latency: with accept in cycle 0, gnt in cycle 1 and rvalid in cycle 2, rsp_valid SHALL first be high in cycle 3; a rejected access SHALL give rsp_valid in cycle 1.
REQ-037 mem_we SHALL equal the latched we in REQ and be 0 otherwise.
REQ-038 mem_addr, mem_be and mem_wdata SHALL be 0 outside REQ.

Reset
REQ-039 While rst=1 at a clock edge, the following SHALL be set: state IDLE, counter 0, all outputs 0 (including req_ready); req_ready rises the cycle after rst falls.
REQ-040 Reset during REQ or WAIT SHALL abandon the transaction without a response; any subsequent mem_rvalid SHALL be ignored.

Verification
REQ-041 Load lb, addr 0x103, mem_rdata 0x80FF_1234 -> mem_be=1000, mem_addr=0x100, rsp_rdata=0xFFFF_FF80, rsp_err=0.
REQ-042 Store sh, addr 0x22, wdata 0x0000_ABCD, gnt delayed 3 cycles -> mem_req held 4 cycles, mem_be=1100, mem_wdata=0xABCD_ABCD; rsp_valid after rvalid.
REQ-043 Load lw, addr 0x6 -> no mem_req, rsp_valid cycle 1, rsp_err=1; load lhu, addr 0x2, mem_rdata 0x9000_0000 -> rsp_rdata=0x0000_9000.
REQ-044 TIMEOUT=4, no mem_rvalid -> rsp_err=1 after 4 WAIT cycles; a later rvalid is ignored and the next request completes normally.
REQ-045 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0; rst=1 in WAIT -> all outputs 0 next cycle, no response.
